// File: rtl/worker_ocimem_pkg.sv
// rtl/worker_ocimem_pkg.sv - shared types and constants for the worker CPU OCI RAM arbiter
package worker_ocimem_pkg;

    typedef enum logic [1:0] {IDLE, JT_RD, AV_RD, AV_ACK} state_t;
    typedef enum logic [2:0] {NONE, LOAD, LOAD_RD, WR, RD_INC} jcmd_t;

    localparam int JDO_ADDR_LSB  = 10;
    localparam int JDO_ADDR_MSB  = 17;
    localparam int JDO_RD_BIT    = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_MSB = 34;

    localparam logic [7:0] PROTECT_BASE = 8'hE0;

    localparam logic GNT_AV = 1'b0;
    localparam logic GNT_JT = 1'b1;

endpackage

// File: rtl/worker_ocimem_rr_arb.sv
// rtl/worker_ocimem_rr_arb.sv - two-requester round-robin arbiter with last-grant memory
module worker_ocimem_rr_arb
    import worker_ocimem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_jt,
    input  logic req_av,
    input  logic update,
    output logic gnt_jt,
    output logic gnt_av
);

    logic last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_jt = req_jt && (!req_av || last_grant == GNT_AV);
        gnt_av = req_av && !gnt_jt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= GNT_AV;
        end else if (update && (gnt_jt || gnt_av)) begin
            last_grant <= gnt_jt ? GNT_JT : GNT_AV;
        end
    end

endmodule

// File: rtl/worker_cpu_ocimem_arbiter.sv
// rtl/worker_cpu_ocimem_arbiter.sv - shares the OCI RAM between JTAG debug and Avalon; WORKER_OCIMEM_PROTECT_EN guards monitor-code writes
module worker_cpu_ocimem_arbiter
    import worker_ocimem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
`ifdef WORKER_OCIMEM_PROTECT_EN
    ,
    output logic              av_protect_hit
`endif
);

    state_t            state, state_nxt;
    jcmd_t             pend_cmd, new_cmd;
    logic              pend, jt_inc, strobe, accept;
    logic [ADDR_W-1:0] pend_addr, jtag_addr;
    logic [31:0]       pend_data;
    logic [1:0]        lat_cnt;
    logic              rd_done, req_jt, req_av, gnt_jt, gnt_av, load_done;
    logic              jt_wr_go, jt_rd_go, jt_rd_done, av_wr_go, av_rd_go, av_rd_done, prot;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    always_comb begin
        strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        if (take_action_ocimem_a)         new_cmd = jdo[JDO_RD_BIT] ? LOAD_RD : LOAD;
        else if (take_action_ocimem_b)    new_cmd = WR;
        else if (take_no_action_ocimem_a) new_cmd = RD_INC;
        else                              new_cmd = NONE;
    end

    // One-deep JTAG queue: nothing new is accepted while a command waits or reads.
    assign accept    = strobe && !pend && (state != JT_RD);
    assign load_done = (state == IDLE) && pend && (pend_cmd == LOAD);
    assign req_jt    = (state == IDLE) && pend && (pend_cmd != LOAD);
    assign req_av    = (state == IDLE) && (av_read || av_write);
    assign rd_done   = (lat_cnt == 2'(RAM_RD_LAT));

    worker_ocimem_rr_arb u_rr_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_jt  (req_jt),
        .req_av  (req_av),
        .update  (state == IDLE),
        .gnt_jt  (gnt_jt),
        .gnt_av  (gnt_av)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_jt && pend_cmd != WR) state_nxt = JT_RD;
                else if (gnt_av)              state_nxt = av_write ? AV_ACK : AV_RD;
            end
            JT_RD:   if (rd_done) state_nxt = IDLE;
            AV_RD:   if (rd_done) state_nxt = AV_ACK;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        jt_wr_go   = gnt_jt && (pend_cmd == WR);
        jt_rd_go   = gnt_jt && (pend_cmd != WR);
        av_wr_go   = gnt_av && av_write;
        av_rd_go   = gnt_av && !av_write;
        jt_rd_done = (state == JT_RD) && rd_done;
        av_rd_done = (state == AV_RD) && rd_done;
`ifdef WORKER_OCIMEM_PROTECT_EN
        prot       = av_wr_go && (av_address >= ADDR_W'(PROTECT_BASE));
`else
        prot       = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonDReg        <= '0;
            monitor_ready  <= 1'b0;
            monitor_error  <= 1'b0;
            av_readdata    <= '0;
            av_waitrequest <= 1'b1;
            ram_wr         <= 1'b0;
            ram_addr       <= '0;
            ram_be         <= '0;
            ram_wdata      <= '0;
            jtag_addr      <= '0;
            pend           <= 1'b0;
            pend_cmd       <= NONE;
            pend_addr      <= '0;
            pend_data      <= '0;
            jt_inc         <= 1'b0;
            lat_cnt        <= '0;
`ifdef WORKER_OCIMEM_PROTECT_EN
            av_protect_hit <= 1'b0;
`endif
        end else begin
            ram_wr         <= 1'b0;
            av_waitrequest <= 1'b1;
            lat_cnt        <= (state == JT_RD || state == AV_RD) ? lat_cnt + 2'd1 : 2'd0;
`ifdef WORKER_OCIMEM_PROTECT_EN
            av_protect_hit <= prot;
`endif
            if (accept) begin
                pend          <= 1'b1;
                pend_cmd      <= new_cmd;
                pend_addr     <= ADDR_W'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
                pend_data     <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                monitor_ready <= 1'b0;
                if (take_action_ocimem_a) monitor_error <= 1'b0;
            end else if (strobe) begin
                monitor_error <= 1'b1;
            end
            if (load_done || gnt_jt) pend <= 1'b0;
            if (load_done) begin
                jtag_addr     <= pend_addr;
                monitor_ready <= 1'b1;
            end
            if (jt_wr_go) begin
                ram_wr        <= 1'b1;
                ram_be        <= 4'hF;
                ram_addr      <= jtag_addr;
                ram_wdata     <= pend_data;
                jtag_addr     <= jtag_addr + 1'b1;
                monitor_ready <= 1'b1;
            end
            if (jt_rd_go) begin
                ram_addr <= (pend_cmd == LOAD_RD) ? pend_addr : jtag_addr;
                jt_inc   <= (pend_cmd == RD_INC);
                if (pend_cmd == LOAD_RD) jtag_addr <= pend_addr;
            end
            if (jt_rd_done) begin
                MonDReg       <= ram_rdata;
                monitor_ready <= 1'b1;
                if (jt_inc) jtag_addr <= jtag_addr + 1'b1;
            end
            if (av_wr_go) begin
                ram_wr         <= !prot;
                ram_be         <= av_byteenable;
                ram_addr       <= av_address;
                ram_wdata      <= av_writedata;
                av_waitrequest <= 1'b0;
            end
            if (av_rd_go) ram_addr <= av_address;
            if (av_rd_done) begin
                av_readdata    <= ram_rdata;
                av_waitrequest <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_worker_cpu_ocimem_arbiter.sv
// tb/tb_worker_cpu_ocimem_arbiter.sv - vector table, corner sequences and random ops against a transaction-level memory model
module tb_worker_cpu_ocimem_arbiter;

    localparam int LAT = 1;
`ifdef WORKER_OCIMEM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
`ifdef WORKER_OCIMEM_PROTECT_EN
    logic        av_protect_hit;
`endif

    always #5 clk = ~clk;

    worker_cpu_ocimem_arbiter #(.ADDR_W(8), .RAM_RD_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a), .jdo(jdo),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_be(ram_be), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef WORKER_OCIMEM_PROTECT_EN
        , .av_protect_hit(av_protect_hit)
`endif
    );

    // Synchronous RAM with LAT cycles of read latency.
    logic [31:0] mem [256];
    logic [7:0]  rd_pipe [LAT];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_wr)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        rd_pipe[0] <= ram_addr;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = mem[rd_pipe[LAT-1]];

    int          wr_cnt = 0, ph_cnt = 0;
    logic [7:0]  wr_log [$];
    logic [7:0]  last_waddr;
    logic [3:0]  last_wbe;
    always @(negedge clk) begin
        if (ram_wr) begin
            wr_cnt++;
            wr_log.push_back(ram_addr);
            last_waddr = ram_addr;
            last_wbe   = ram_be;
        end
`ifdef WORKER_OCIMEM_PROTECT_EN
        if (av_protect_hit) ph_cnt++;
`endif
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef enum int {OP_JLOAD, OP_JLOADRD, OP_JWR, OP_JRDINC, OP_AVWR, OP_AVRD} op_e;

    // Transaction-level reference: a word array plus the JTAG address pointer.
    logic [31:0] ref_mem [256];
    logic [7:0]  ref_ja = 8'h00;
    initial for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    task automatic model(input op_e op, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                         output int e_nwr, output logic [7:0] e_waddr, output logic [31:0] e_rd);
        e_nwr = 0; e_waddr = '0; e_rd = '0;
        case (op)
            OP_JLOAD:   ref_ja = a;
            OP_JLOADRD: begin ref_ja = a; e_rd = ref_mem[a]; end
            OP_JWR:     begin e_nwr = 1; e_waddr = ref_ja; ref_mem[ref_ja] = d; ref_ja = ref_ja + 8'd1; end
            OP_JRDINC:  begin e_rd = ref_mem[ref_ja]; ref_ja = ref_ja + 8'd1; end
            OP_AVWR: begin
                if (!(PROT_EN && a >= 8'hE0)) begin
                    e_nwr = 1; e_waddr = a;
                    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                end
            end
            default:    e_rd = ref_mem[a];
        endcase
    endtask

    task automatic run_op(input op_e op, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int pre, output logic [31:0] rd, output int lat, output int nwr);
        int w0;
        repeat (pre) @(posedge clk);
        w0 = wr_cnt;
        lat = 0;
        @(posedge clk); #1;
        if (op == OP_AVWR || op == OP_AVRD) begin
            av_address = a; av_writedata = d; av_byteenable = be;
            av_read = (op == OP_AVRD); av_write = (op == OP_AVWR);
            @(negedge clk);
            while (av_waitrequest && lat < 50) begin @(negedge clk); lat++; end
            chk("av_ack_seen", {31'b0, av_waitrequest}, 32'd0);
            rd = av_readdata;
            @(posedge clk); #1;
            av_read = 1'b0; av_write = 1'b0;
        end else begin
            jdo = '0;
            case (op)
                OP_JLOAD:   begin take_action_ocimem_a = 1'b1; jdo[17:10] = a; end
                OP_JLOADRD: begin take_action_ocimem_a = 1'b1; jdo[17:10] = a; jdo[34] = 1'b1; end
                OP_JWR:     begin take_action_ocimem_b = 1'b1; jdo[34:3] = d; end
                default:    take_no_action_ocimem_a = 1'b1;
            endcase
            @(posedge clk); #1;
            take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
            while (!monitor_ready && lat < 50) begin @(negedge clk); lat++; end
            chk("jtag_ready_seen", {31'b0, monitor_ready}, 32'd1);
            rd = MonDReg;
            @(posedge clk); #1;
        end
        nwr = wr_cnt - w0;
    endtask

    typedef struct {
        op_e         op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          exp_nwr;
        logic [7:0]  exp_waddr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] rd, rd2, e_rd;
    int          lat, lat2, nwr, nwr2, e_nwr, n0, w0;
    logic [7:0]  e_waddr, ja_before;

    initial begin
        vecs[0]  = '{OP_JLOAD,   8'h10, 32'h0,        4'h0, 0, 8'h00, 32'h0};
        vecs[1]  = '{OP_JWR,     8'h00, 32'hDEADBEEF, 4'h0, 1, 8'h10, 32'h0};
        vecs[2]  = '{OP_JWR,     8'h00, 32'h12345678, 4'h0, 1, 8'h11, 32'h0};
        vecs[3]  = '{OP_JLOAD,   8'h10, 32'h0,        4'h0, 0, 8'h00, 32'h0};
        vecs[4]  = '{OP_JRDINC,  8'h00, 32'h0,        4'h0, 0, 8'h00, 32'hDEADBEEF};
        vecs[5]  = '{OP_JRDINC,  8'h00, 32'h0,        4'h0, 0, 8'h00, 32'h12345678};
        vecs[6]  = '{OP_AVRD,    8'h10, 32'h0,        4'h0, 0, 8'h00, 32'hDEADBEEF};
        vecs[7]  = '{OP_AVWR,    8'h11, 32'hCAFEF00D, 4'h3, 1, 8'h11, 32'h0};
        vecs[8]  = '{OP_AVRD,    8'h11, 32'h0,        4'h0, 0, 8'h00, 32'h1234F00D};
        vecs[9]  = '{OP_JLOADRD, 8'h11, 32'h0,        4'h0, 0, 8'h00, 32'h1234F00D};
        vecs[10] = '{OP_JRDINC,  8'h00, 32'h0,        4'h0, 0, 8'h00, 32'h1234F00D};
        vecs[11] = '{OP_JLOAD,   8'hFF, 32'h0,        4'h0, 0, 8'h00, 32'h0};
        vecs[12] = '{OP_JWR,     8'h00, 32'h0BADF00D, 4'h0, 1, 8'hFF, 32'h0};
        vecs[13] = '{OP_JWR,     8'h00, 32'h00000001, 4'h0, 1, 8'h00, 32'h0};
        vecs[14] = '{OP_AVRD,    8'h00, 32'h0,        4'h0, 0, 8'h00, 32'h00000001};
        vecs[15] = '{OP_AVRD,    8'hFF, 32'h0,        4'h0, 0, 8'h00, 32'h0BADF00D};

        reset_n = 1'b0; jdo = '0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0; av_byteenable = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_ready", {31'b0, monitor_ready}, 32'd0);
        chk("rst_error", {31'b0, monitor_error}, 32'd0);
        chk("rst_av_readdata", av_readdata, 32'h0);
        chk("rst_waitrequest", {31'b0, av_waitrequest}, 32'd1);
        chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
        chk("rst_ram_addr", {24'b0, ram_addr}, 32'h0);
        chk("rst_ram_be", {28'b0, ram_be}, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].be, 0, rd, lat, nwr);
            model(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].be, e_nwr, e_waddr, e_rd);
            chk($sformatf("vec%0d_nwr", i), nwr, vecs[i].exp_nwr);
            if (vecs[i].exp_nwr > 0) begin
                chk($sformatf("vec%0d_waddr", i), {24'b0, last_waddr}, {24'b0, vecs[i].exp_waddr});
                chk($sformatf("vec%0d_wbe", i), {28'b0, last_wbe},
                    {28'b0, (vecs[i].op == OP_JWR) ? 4'hF : vecs[i].be});
            end
            if (vecs[i].op inside {OP_JLOADRD, OP_JRDINC, OP_AVRD})
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            if (vecs[i].op == OP_AVRD) chk($sformatf("vec%0d_rd_lat", i), lat, LAT + 2);
            if (vecs[i].op == OP_AVWR) chk($sformatf("vec%0d_wr_lat", i), lat, 1);
        end

        // Collision: a second strobe while the first read is in flight is dropped.
        w0 = wr_cnt;
        model(OP_JRDINC, 8'h00, 32'h0, 4'h0, e_nwr, e_waddr, e_rd);
        @(posedge clk); #1 take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1 take_no_action_ocimem_a = 1'b0;
        @(posedge clk); #1 take_action_ocimem_b = 1'b1; jdo = '0; jdo[34:3] = 32'hBAD0BAD0;
        @(posedge clk); #1 take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("err_set", {31'b0, monitor_error}, 32'd1);
        lat = 0;
        while (!monitor_ready && lat < 50) begin @(negedge clk); lat++; end
        chk("err_first_read_ready", {31'b0, monitor_ready}, 32'd1);
        chk("err_first_read_data", MonDReg, e_rd);
        repeat (3) @(posedge clk);
        chk("err_dropped_no_write", wr_cnt - w0, 32'd0);
        run_op(OP_JWR, 8'h00, 32'h600DF00D, 4'h0, 0, rd, lat, nwr);
        model(OP_JWR, 8'h00, 32'h600DF00D, 4'h0, e_nwr, e_waddr, e_rd);
        chk("err_sticky_after_b", {31'b0, monitor_error}, 32'd1);
        run_op(OP_JLOAD, 8'h20, 32'h0, 4'h0, 0, rd, lat, nwr);
        model(OP_JLOAD, 8'h20, 32'h0, 4'h0, e_nwr, e_waddr, e_rd);
        chk("err_cleared_by_a", {31'b0, monitor_error}, 32'd0);

        // Round-robin: last winner Avalon -> JTAG first; last winner JTAG -> Avalon first.
        run_op(OP_AVWR, 8'h40, 32'h1, 4'hF, 0, rd, lat, nwr);
        model(OP_AVWR, 8'h40, 32'h1, 4'hF, e_nwr, e_waddr, e_rd);
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                run_op(OP_JWR, 8'h00, 32'h77, 4'h0, 0, rd, lat, nwr);
                model(OP_JWR, 8'h00, 32'h77, 4'h0, e_nwr, e_waddr, e_rd);
            end
            n0 = wr_log.size();
            ja_before = ref_ja;
            fork
                run_op(OP_JWR, 8'h00, 32'hA0 + r, 4'h0, 0, rd, lat, nwr);
                run_op(OP_AVWR, 8'h60, 32'hB0 + r, 4'hF, 1, rd2, lat2, nwr2);
            join
            model(OP_JWR, 8'h00, 32'hA0 + r, 4'h0, e_nwr, e_waddr, e_rd);
            model(OP_AVWR, 8'h60, 32'hB0 + r, 4'hF, e_nwr, e_waddr, e_rd);
            chk($sformatf("rr%0d_nwrites", r), wr_log.size() - n0, 32'd2);
            if (wr_log.size() >= n0 + 2) begin
                chk($sformatf("rr%0d_first", r), {24'b0, wr_log[n0]}, {24'b0, (r == 0) ? ja_before : 8'h60});
                chk($sformatf("rr%0d_second", r), {24'b0, wr_log[n0+1]}, {24'b0, (r == 0) ? 8'h60 : ja_before});
            end
        end

`ifdef WORKER_OCIMEM_PROTECT_EN
        run_op(OP_JLOAD, 8'hE4, 32'h0, 4'h0, 0, rd, lat, nwr);
        model(OP_JLOAD, 8'hE4, 32'h0, 4'h0, e_nwr, e_waddr, e_rd);
        run_op(OP_JWR, 8'h00, 32'h11112222, 4'h0, 0, rd, lat, nwr);
        model(OP_JWR, 8'h00, 32'h11112222, 4'h0, e_nwr, e_waddr, e_rd);
        chk("prot_jtag_write_allowed", nwr, 32'd1);
        n0 = ph_cnt;
        run_op(OP_AVWR, 8'hE4, 32'h12345678, 4'hF, 0, rd, lat, nwr);
        model(OP_AVWR, 8'hE4, 32'h12345678, 4'hF, e_nwr, e_waddr, e_rd);
        chk("prot_suppressed", nwr, 32'd0);
        chk("prot_hit", ph_cnt - n0, 32'd1);
        chk("prot_ack_lat", lat, 32'd1);
        run_op(OP_JLOADRD, 8'hE4, 32'h0, 4'h0, 0, rd, lat, nwr);
        model(OP_JLOADRD, 8'hE4, 32'h0, 4'h0, e_nwr, e_waddr, e_rd);
        chk("prot_old_value", rd, 32'h11112222);
        n0 = ph_cnt;
        run_op(OP_AVWR, 8'hDF, 32'h5, 4'hF, 0, rd, lat, nwr);
        model(OP_AVWR, 8'hDF, 32'h5, 4'hF, e_nwr, e_waddr, e_rd);
        chk("prot_below_base_writes", nwr, 32'd1);
        chk("prot_below_base_no_hit", ph_cnt - n0, 32'd0);
`endif

        for (int i = 0; i < 120; i++) begin
            op_e         op;
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  be;
            op = op_e'($urandom_range(0, 5));
            a  = 8'($urandom);
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            run_op(op, a, d, be, 0, rd, lat, nwr);
            model(op, a, d, be, e_nwr, e_waddr, e_rd);
            chk($sformatf("rnd%0d_nwr", i), nwr, e_nwr);
            if (e_nwr > 0 && nwr > 0) chk($sformatf("rnd%0d_waddr", i), {24'b0, last_waddr}, {24'b0, e_waddr});
            if (op inside {OP_JLOADRD, OP_JRDINC, OP_AVRD}) chk($sformatf("rnd%0d_rdata", i), rd, e_rd);
            if (op == OP_AVRD) chk($sformatf("rnd%0d_lat", i), lat, LAT + 2);
            if (op == OP_AVWR) chk($sformatf("rnd%0d_lat", i), lat, 1);
        end

        // Reset while a JTAG write is pending: no write and no ready afterwards.
        w0 = wr_cnt;
        @(posedge clk); #1 take_action_ocimem_b = 1'b1; jdo = '0; jdo[34:3] = 32'h55;
        @(posedge clk); #1 take_action_ocimem_b = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'b0, monitor_ready}, 32'd0);
        chk("midrst_waitrequest", {31'b0, av_waitrequest}, 32'd1);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_write", wr_cnt - w0, 32'd0);
        chk("midrst_no_ready", {31'b0, monitor_ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
